// File: rtl/svi_mem_pkg.sv
// -----------------------------------------------------------------------------
// svi_mem_pkg
// Shared types and constants for the SVI-328 memory access sequencer.
//   mem_state_e     : sequencer FSM state encoding
//   IOCTL_IDX_*     : ioctl image indices understood by the sequencer
//   DEF_*_BASE      : default physical load bases for downloaded images
//   dl_byte_ok()    : true when a download byte targets a known image and
//                     lies inside the 64 KiB window the sequencer maps
// -----------------------------------------------------------------------------
package svi_mem_pkg;

  localparam int unsigned PHYS_AW = 18;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CPU_RD = 3'd1,
    ST_CPU_WR = 3'd2,
    ST_DL_WR  = 3'd3,
    ST_HOLD   = 3'd4
  } mem_state_e;

  localparam logic [7:0] IOCTL_IDX_ROM  = 8'd0;
  localparam logic [7:0] IOCTL_IDX_CART = 8'd1;

  localparam logic [PHYS_AW-1:0] DEF_ROM_BASE  = 18'h00000;
  localparam logic [PHYS_AW-1:0] DEF_CART_BASE = 18'h10000;

  function automatic logic dl_byte_ok(input logic [7:0] idx, input logic [24:0] ofs);
    return ((idx == IOCTL_IDX_ROM) || (idx == IOCTL_IDX_CART)) && (ofs[24:16] == 9'd0);
  endfunction

endpackage

// File: rtl/svi_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// svi_mem_ctrl_if
// Request/acknowledge port between the sequencer and the variable-latency
// memory.
//   mem_addr  : physical byte address       (master -> slave)
//   mem_din   : write data                  (master -> slave)
//   mem_we    : 1 = write, 0 = read         (master -> slave)
//   mem_req   : held high until mem_ack     (master -> slave)
//   mem_dout  : read data, valid with ack   (slave -> master)
//   mem_ack   : one-cycle completion pulse  (slave -> master)
// -----------------------------------------------------------------------------
interface svi_mem_ctrl_if;
  import svi_mem_pkg::*;

  logic [PHYS_AW-1:0] mem_addr;
  logic [DATA_W-1:0]  mem_din;
  logic               mem_we;
  logic               mem_req;
  logic [DATA_W-1:0]  mem_dout;
  logic               mem_ack;

  modport master (
    output mem_addr, mem_din, mem_we, mem_req,
    input  mem_dout, mem_ack
  );

  modport slave (
    input  mem_addr, mem_din, mem_we, mem_req,
    output mem_dout, mem_ack
  );

endinterface

// File: rtl/svi_access_detect.sv
// -----------------------------------------------------------------------------
// svi_access_detect
// Turns the Z80 memory strobes into at most one request pulse per CPU memory
// cycle. The detector arms while MREQ is inactive and disarms on the first
// read or write it reports, so a long stretched cycle yields one pulse only.
// Refresh cycles (MREQ without RD/WR) never fire.
//   i_clk_sys  : system clock
//   i_reset_n  : synchronous active-low reset (re-arms the detector)
//   i_mreq_n   : Z80 MREQ, synchronous to i_clk_sys
//   i_rd_n     : Z80 RD
//   i_wr_n     : Z80 WR
//   o_rd_req   : one-cycle read request pulse (combinational from armed state)
//   o_wr_req   : one-cycle write request pulse
// -----------------------------------------------------------------------------
module svi_access_detect (
  input  logic i_clk_sys,
  input  logic i_reset_n,
  input  logic i_mreq_n,
  input  logic i_rd_n,
  input  logic i_wr_n,
  output logic o_rd_req,
  output logic o_wr_req
);

  logic r_armed;
  logic w_rd_hit;
  logic w_wr_hit;

  // Read wins if a glitchy bus ever shows both strobes at once.
  assign w_rd_hit = r_armed & ~i_mreq_n & ~i_rd_n;
  assign w_wr_hit = r_armed & ~i_mreq_n &  i_rd_n & ~i_wr_n;

  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) begin
      r_armed <= 1'b1;
    end else if (w_rd_hit || w_wr_hit) begin
      r_armed <= 1'b0;
    end else if (i_mreq_n) begin
      r_armed <= 1'b1;
    end
  end

  assign o_rd_req = w_rd_hit;
  assign o_wr_req = w_wr_hit;

endmodule

// File: rtl/svi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// svi_mem_ctrl
// Memory access sequencer behind the SVI-328 bank mapper. Runs one memory
// transaction per Z80 memory cycle, stretching the CPU with WAIT until the
// memory acknowledges, and interleaves ROM/cartridge image downloads from the
// ioctl channel (downloads take priority over the CPU).
//
// Parameters
//   CART_BASE : physical base for cartridge images (index 1)
//   ROM_BASE  : physical base for BASIC ROM images (index 0)
//
// Ports
//   i_clk_sys         : system clock, all logic on the rising edge
//   i_reset_n         : synchronous active-low reset
//   i_cpu_addr        : mapped 18-bit physical address
//   i_cpu_ram         : 1 = RAM (writable), 0 = ROM (writes dropped)
//   i_cpu_mreq_n/rd_n/wr_n : Z80 strobes, synchronous to i_clk_sys
//   i_cpu_din         : Z80 write data
//   o_cpu_dout        : read data to the Z80, held between reads
//   o_cpu_wait_n      : registered Z80 WAIT
//   i_ioctl_download  : download in progress
//   i_ioctl_index     : image index (0 ROM, 1 cartridge, others ignored)
//   i_ioctl_wr        : one-cycle byte strobe
//   i_ioctl_addr      : byte offset within the image
//   i_ioctl_dout      : image byte
//   o_ioctl_wait      : high while a captured byte awaits its memory ack
//   mem               : memory request/ack port (master side)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no transaction; picks download byte, then CPU read/write
// ST_CPU_RD | CPU read request outstanding, cpu_dout loads on ack
// ST_CPU_WR | CPU write request outstanding
// ST_DL_WR  | download byte write outstanding
// ST_HOLD   | CPU cycle finished (or ROM write dropped); wait for MREQ high
// -----------------------------------------------------------------------------
module svi_mem_ctrl
  import svi_mem_pkg::*;
#(
  parameter logic [17:0] CART_BASE = DEF_CART_BASE,
  parameter logic [17:0] ROM_BASE  = DEF_ROM_BASE
) (
  input  logic        i_clk_sys,
  input  logic        i_reset_n,
  input  logic [17:0] i_cpu_addr,
  input  logic        i_cpu_ram,
  input  logic        i_cpu_mreq_n,
  input  logic        i_cpu_rd_n,
  input  logic        i_cpu_wr_n,
  input  logic [7:0]  i_cpu_din,
  output logic [7:0]  o_cpu_dout,
  output logic        o_cpu_wait_n,
  input  logic        i_ioctl_download,
  input  logic [7:0]  i_ioctl_index,
  input  logic        i_ioctl_wr,
  input  logic [24:0] i_ioctl_addr,
  input  logic [7:0]  i_ioctl_dout,
  output logic        o_ioctl_wait,
  svi_mem_ctrl_if.master mem
);

  logic w_rd_req;
  logic w_wr_req;

  svi_access_detect u_detect (
    .i_clk_sys (i_clk_sys),
    .i_reset_n (i_reset_n),
    .i_mreq_n  (i_cpu_mreq_n),
    .i_rd_n    (i_cpu_rd_n),
    .i_wr_n    (i_cpu_wr_n),
    .o_rd_req  (w_rd_req),
    .o_wr_req  (w_wr_req)
  );

  mem_state_e  r_state;
  mem_state_e  w_state_nxt;

  logic        r_mem_req,  w_req_nxt;
  logic        r_mem_we,   w_we_nxt;
  logic [17:0] r_mem_addr, w_addr_nxt;
  logic [7:0]  r_mem_din,  w_din_nxt;
  logic [7:0]  r_cpu_dout, w_dout_nxt;
  logic        r_cpu_wait_n, w_wait_n_nxt;

  // A CPU request that could not be started yet (download active or busy).
  logic        r_pend_rd, w_pend_rd_nxt;
  logic        r_pend_wr, w_pend_wr_nxt;
  logic        w_cpu_rd;
  logic        w_cpu_wr;

  // One-entry download holding register.
  logic        r_hold_vld;
  logic [17:0] r_hold_addr;
  logic [7:0]  r_hold_data;
  logic        w_hold_clr;
  logic        w_ioctl_cap;
  logic [17:0] w_dl_base;
  logic [17:0] w_dl_addr_in;
  logic        w_dl_pend;
  logic [17:0] w_dl_addr;
  logic [7:0]  w_dl_data;

  assign w_cpu_rd = r_pend_rd | w_rd_req;
  assign w_cpu_wr = r_pend_wr | w_wr_req;

  // A strobe while the holding register is full is a protocol error and is
  // dropped; out-of-window or unknown-index bytes never enter the register.
  assign w_ioctl_cap  = i_ioctl_wr & ~r_hold_vld & dl_byte_ok(i_ioctl_index, i_ioctl_addr);
  assign w_dl_base    = (i_ioctl_index == IOCTL_IDX_CART) ? CART_BASE : ROM_BASE;
  assign w_dl_addr_in = w_dl_base + {2'b00, i_ioctl_addr[15:0]};

  // The byte arriving this cycle is usable immediately so that a same-cycle
  // CPU detect loses to it.
  assign w_dl_pend = r_hold_vld | w_ioctl_cap;
  assign w_dl_addr = r_hold_vld ? r_hold_addr : w_dl_addr_in;
  assign w_dl_data = r_hold_vld ? r_hold_data : i_ioctl_dout;

  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) begin
      r_hold_vld  <= 1'b0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
    end else if (w_ioctl_cap) begin
      r_hold_vld  <= 1'b1;
      r_hold_addr <= w_dl_addr_in;
      r_hold_data <= i_ioctl_dout;
    end else if (w_hold_clr) begin
      r_hold_vld  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_cpu_dout   <= 8'hFF;
      r_cpu_wait_n <= 1'b1;
      r_pend_rd    <= 1'b0;
      r_pend_wr    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_req    <= w_req_nxt;
      r_mem_we     <= w_we_nxt;
      r_mem_addr   <= w_addr_nxt;
      r_mem_din    <= w_din_nxt;
      r_cpu_dout   <= w_dout_nxt;
      r_cpu_wait_n <= w_wait_n_nxt;
      r_pend_rd    <= w_pend_rd_nxt;
      r_pend_wr    <= w_pend_wr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_mem_req;
    w_we_nxt      = r_mem_we;
    w_addr_nxt    = r_mem_addr;
    w_din_nxt     = r_mem_din;
    w_dout_nxt    = r_cpu_dout;
    w_wait_n_nxt  = r_cpu_wait_n;
    w_pend_rd_nxt = w_cpu_rd;
    w_pend_wr_nxt = w_cpu_wr;
    w_hold_clr    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_dl_pend) begin
          w_state_nxt = ST_DL_WR;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = w_dl_addr;
          w_din_nxt   = w_dl_data;
          if (w_cpu_rd || w_cpu_wr) begin
            w_wait_n_nxt = 1'b0;
          end
        end else if (w_cpu_rd) begin
          w_wait_n_nxt = 1'b0;
          if (!i_ioctl_download) begin
            w_state_nxt   = ST_CPU_RD;
            w_req_nxt     = 1'b1;
            w_we_nxt      = 1'b0;
            w_addr_nxt    = i_cpu_addr;
            w_pend_rd_nxt = 1'b0;
            w_pend_wr_nxt = 1'b0;
          end
        end else if (w_cpu_wr) begin
          if (!i_cpu_ram) begin
            // ROM write: nothing to do in memory, let the CPU run on.
            w_state_nxt   = ST_HOLD;
            w_wait_n_nxt  = 1'b1;
            w_pend_wr_nxt = 1'b0;
          end else begin
            w_wait_n_nxt = 1'b0;
            if (!i_ioctl_download) begin
              w_state_nxt   = ST_CPU_WR;
              w_req_nxt     = 1'b1;
              w_we_nxt      = 1'b1;
              w_addr_nxt    = i_cpu_addr;
              w_din_nxt     = i_cpu_din;
              w_pend_wr_nxt = 1'b0;
            end
          end
        end
      end

      ST_CPU_RD: begin
        if (mem.mem_ack) begin
          w_state_nxt  = ST_HOLD;
          w_req_nxt    = 1'b0;
          w_dout_nxt   = mem.mem_dout;
          w_wait_n_nxt = 1'b1;
        end
      end

      ST_CPU_WR: begin
        if (mem.mem_ack) begin
          w_state_nxt  = ST_HOLD;
          w_req_nxt    = 1'b0;
          w_we_nxt     = 1'b0;
          w_wait_n_nxt = 1'b1;
        end
      end

      ST_DL_WR: begin
        // A CPU cycle starting behind a download byte is stalled right away.
        if (w_rd_req || w_wr_req) begin
          w_wait_n_nxt = 1'b0;
        end
        if (mem.mem_ack) begin
          w_state_nxt = ST_IDLE;
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_hold_clr  = 1'b1;
        end
      end

      ST_HOLD: begin
        w_wait_n_nxt = 1'b1;
        if (i_cpu_mreq_n) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign mem.mem_req  = r_mem_req;
  assign mem.mem_we   = r_mem_we;
  assign mem.mem_addr = r_mem_addr;
  assign mem.mem_din  = r_mem_din;

  assign o_cpu_dout   = r_cpu_dout;
  assign o_cpu_wait_n = r_cpu_wait_n;
  assign o_ioctl_wait = r_hold_vld;

endmodule

// File: tb/tb_svi_mem_ctrl.sv
module tb_svi_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] cpu_addr = '0;
  logic        cpu_ram = 1'b0;
  logic        cpu_mreq_n = 1'b1;
  logic        cpu_rd_n = 1'b1;
  logic        cpu_wr_n = 1'b1;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  o_cpu_dout;
  logic        o_cpu_wait_n;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        o_ioctl_wait;

  svi_mem_ctrl_if mif ();

  svi_mem_ctrl dut (
    .i_clk_sys        (clk),
    .i_reset_n        (reset_n),
    .i_cpu_addr       (cpu_addr),
    .i_cpu_ram        (cpu_ram),
    .i_cpu_mreq_n     (cpu_mreq_n),
    .i_cpu_rd_n       (cpu_rd_n),
    .i_cpu_wr_n       (cpu_wr_n),
    .i_cpu_din        (cpu_din),
    .o_cpu_dout       (o_cpu_dout),
    .o_cpu_wait_n     (o_cpu_wait_n),
    .i_ioctl_download (ioctl_download),
    .i_ioctl_index    (ioctl_index),
    .i_ioctl_wr       (ioctl_wr),
    .i_ioctl_addr     (ioctl_addr),
    .i_ioctl_dout     (ioctl_dout),
    .o_ioctl_wait     (o_ioctl_wait),
    .mem              (mif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model controls (written by the test) and observations (written by
  // the model only).
  int          lat = 1;
  logic [7:0]  rdata = '0;
  int          stray_cnt = 0;
  int          stray_seen = 0;
  int          n_req = 0;
  int          n_wait_low = 0;
  int          n_iowait = 0;
  logic [17:0] last_addr = '0;
  logic        last_we = 1'b0;
  logic [7:0]  last_din = '0;

  // Variable-latency memory: runs 1ns after each rising edge. With lat=k the
  // ack is sampled k+1 edges after mem_req rises, i.e. k cycles after the
  // first request cycle.
  initial begin
    int   age;
    logic prev_req;
    age = 0;
    prev_req = 1'b0;
    mif.mem_ack = 1'b0;
    mif.mem_dout = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mif.mem_ack) begin
        mif.mem_ack = 1'b0;
        age = 0;
      end else if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        mif.mem_ack = 1'b1;
        mif.mem_dout = 8'hEE;
      end else if (mif.mem_req) begin
        age = age + 1;
        if (age == lat + 1) begin
          mif.mem_ack = 1'b1;
          mif.mem_dout = rdata;
        end
      end else begin
        age = 0;
      end
      if (mif.mem_req && !prev_req) begin
        n_req = n_req + 1;
        last_addr = mif.mem_addr;
        last_we = mif.mem_we;
        last_din = mif.mem_din;
      end
      prev_req = mif.mem_req;
      if (!o_cpu_wait_n) n_wait_low = n_wait_low + 1;
      if (o_ioctl_wait) n_iowait = n_iowait + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cpu_release(input string name, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (o_cpu_wait_n) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s: cpu_wait_n still low after %0d cycles", name, max_cycles);
    end
  endtask

  task automatic wait_ioctl_idle(input string name, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!o_ioctl_wait) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s: ioctl_wait still high after %0d cycles", name, max_cycles);
    end
  endtask

  task automatic cpu_access(input string name, input logic wr, input logic ram,
                            input logic [17:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    cpu_addr = a;
    cpu_ram = ram;
    cpu_din = d;
    cpu_mreq_n = 1'b0;
    if (wr) cpu_wr_n = 1'b0;
    else    cpu_rd_n = 1'b0;
    wait_cpu_release(name, 64);
    repeat (hold) @(negedge clk);
    cpu_mreq_n = 1'b1;
    cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic ioctl_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_index = idx;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic        ram;
    logic [17:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          lat;
    int          hold;
    int          exp_reqs;
    logic        exp_we;
    logic [7:0]  exp_dout;
    int          exp_wait;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  initial begin
    int r0;
    int w0;
    int io0;

    // wr ram addr wdata rdata lat hold reqs we dout waitlow
    vecs[0] = '{1'b0, 1'b1, 18'h18000, 8'h00, 8'h5A, 3, 2, 1, 1'b0, 8'h5A, 4};
    vecs[1] = '{1'b1, 1'b0, 18'h05000, 8'hC3, 8'h00, 1, 5, 0, 1'b0, 8'h5A, 0};
    vecs[2] = '{1'b1, 1'b1, 18'h2C000, 8'h77, 8'h00, 1, 18, 1, 1'b1, 8'h5A, 2};
    vecs[3] = '{1'b0, 1'b1, 18'h3FFFF, 8'h00, 8'h3C, 1, 0, 1, 1'b0, 8'h3C, 2};
    vecs[4] = '{1'b0, 1'b0, 18'h00010, 8'h00, 8'hA5, 0, 1, 1, 1'b0, 8'hA5, 1};
    vecs[5] = '{1'b1, 1'b1, 18'h10000, 8'h01, 8'h00, 5, 0, 1, 1'b1, 8'hA5, 6};

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout",     32'(o_cpu_dout), 'hFF);
    check("rst_wait_n",   32'(o_cpu_wait_n), 1);
    check("rst_ioctl_wt", 32'(o_ioctl_wait), 0);
    check("rst_req",      32'(mif.mem_req), 0);
    check("rst_we",       32'(mif.mem_we), 0);
    check("rst_addr",     32'(mif.mem_addr), 0);
    check("rst_din",      32'(mif.mem_din), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // CPU transaction table
    for (int v = 0; v < NV; v++) begin
      lat = vecs[v].lat;
      rdata = vecs[v].rdata;
      r0 = n_req;
      w0 = n_wait_low;
      cpu_access($sformatf("v%0d_timeout", v), vecs[v].wr, vecs[v].ram,
                 vecs[v].addr, vecs[v].wdata, vecs[v].hold);
      check($sformatf("v%0d_reqs", v), 32'(n_req - r0), 32'(vecs[v].exp_reqs));
      check($sformatf("v%0d_waitlow", v), 32'(n_wait_low - w0), 32'(vecs[v].exp_wait));
      check($sformatf("v%0d_dout", v), 32'(o_cpu_dout), 32'(vecs[v].exp_dout));
      if (vecs[v].exp_reqs != 0) begin
        check($sformatf("v%0d_addr", v), 32'(last_addr), 32'(vecs[v].addr));
        check($sformatf("v%0d_we", v), 32'(last_we), 32'(vecs[v].exp_we));
        if (vecs[v].wr) check($sformatf("v%0d_din", v), 32'(last_din), 32'(vecs[v].wdata));
      end
    end

    // Download byte and CPU read detected in the same cycle
    lat = 1;
    rdata = 8'h99;
    @(negedge clk);
    ioctl_download = 1'b1;
    @(negedge clk);
    r0 = n_req;
    ioctl_index = 8'd1;
    ioctl_addr = 25'h0000123;
    ioctl_dout = 8'hAA;
    ioctl_wr = 1'b1;
    cpu_addr = 18'h00200;
    cpu_ram = 1'b1;
    cpu_mreq_n = 1'b0;
    cpu_rd_n = 1'b0;
    @(negedge clk);
    ioctl_wr = 1'b0;
    check("dl_req",       32'(mif.mem_req), 1);
    check("dl_addr",      32'(mif.mem_addr), 'h10123);
    check("dl_we",        32'(mif.mem_we), 1);
    check("dl_din",       32'(mif.mem_din), 'hAA);
    check("dl_cpu_wait",  32'(o_cpu_wait_n), 0);
    check("dl_ioctl_wt",  32'(o_ioctl_wait), 1);
    wait_ioctl_idle("dl_timeout", 32);
    repeat (4) @(negedge clk);
    check("dl_cpu_held",  32'(o_cpu_wait_n), 0);
    check("dl_held_req",  32'(mif.mem_req), 0);
    check("dl_one_req",   32'(n_req - r0), 1);
    ioctl_download = 1'b0;
    wait_cpu_release("dl_cpu_timeout", 32);
    check("dl_cpu_reqs",  32'(n_req - r0), 2);
    check("dl_cpu_addr",  32'(last_addr), 'h00200);
    check("dl_cpu_we",    32'(last_we), 0);
    check("dl_cpu_dout",  32'(o_cpu_dout), 'h99);
    cpu_mreq_n = 1'b1;
    cpu_rd_n = 1'b1;
    repeat (2) @(negedge clk);

    // Discarded download bytes: out-of-window offset, unknown index
    ioctl_download = 1'b1;
    r0 = n_req;
    io0 = n_iowait;
    ioctl_byte(8'd0, 25'h0010000, 8'h55);
    repeat (4) @(negedge clk);
    check("drop_win_req", 32'(n_req - r0), 0);
    check("drop_win_wt",  32'((n_iowait - io0) <= 1), 1);
    io0 = n_iowait;
    ioctl_byte(8'd2, 25'h0000005, 8'h66);
    repeat (4) @(negedge clk);
    check("drop_idx_req", 32'(n_req - r0), 0);
    check("drop_idx_wt",  32'((n_iowait - io0) <= 1), 1);

    // ROM image byte, with an illegal second strobe while ioctl_wait is high
    lat = 4;
    @(negedge clk);
    ioctl_index = 8'd0;
    ioctl_addr = 25'h0000042;
    ioctl_dout = 8'h3E;
    ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_addr = 25'h0000043;
    ioctl_dout = 8'h11;
    @(negedge clk);
    ioctl_wr = 1'b0;
    wait_ioctl_idle("rom_dl_timeout", 32);
    repeat (3) @(negedge clk);
    check("rom_dl_reqs",  32'(n_req - r0), 1);
    check("rom_dl_addr",  32'(last_addr), 'h00042);
    check("rom_dl_din",   32'(last_din), 'h3E);
    check("rom_dl_we",    32'(last_we), 1);
    check("rom_dl_wt",    32'(o_ioctl_wait), 0);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a CPU read, then a stray ack
    lat = 10;
    @(negedge clk);
    cpu_addr = 18'h01234;
    cpu_ram = 1'b1;
    cpu_mreq_n = 1'b0;
    cpu_rd_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rd_req",   32'(mif.mem_req), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("arst_req",     32'(mif.mem_req), 0);
    check("arst_wait_n",  32'(o_cpu_wait_n), 1);
    check("arst_dout",    32'(o_cpu_dout), 'hFF);
    cpu_mreq_n = 1'b1;
    cpu_rd_n = 1'b1;
    reset_n = 1'b1;
    r0 = n_req;
    @(negedge clk);
    stray_cnt = stray_cnt + 1;
    repeat (3) @(negedge clk);
    check("stray_req",    32'(mif.mem_req), 0);
    check("stray_wait_n", 32'(o_cpu_wait_n), 1);
    check("stray_dout",   32'(o_cpu_dout), 'hFF);
    check("stray_reqs",   32'(n_req - r0), 0);

    // Normal read still works after the abandoned one
    lat = 1;
    rdata = 8'h42;
    cpu_access("post_rst_timeout", 1'b0, 1'b1, 18'h0ABCD, 8'h00, 0);
    check("post_rst_dout", 32'(o_cpu_dout), 'h42);
    check("post_rst_addr", 32'(last_addr), 'h0ABCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/svi_mem_ctrl.md
# svi_mem_ctrl

Memory access sequencer directly downstream of the SVI-328 bank mapper. Takes the mapper's 18-bit physical address and RAM/ROM flag for each Z80 memory cycle, runs exactly one request/acknowledge transaction per CPU cycle against the variable-latency memory port, and stretches the CPU with WAIT until the transaction completes. It also arbitrates ROM/cartridge image downloads from the ioctl channel into the same memory, with download having priority.

## Interface
Parameters:
- CART_BASE, 18'h10000, physical base for cartridge images (bank 1)
- ROM_BASE, 18'h00000, physical base for BASIC ROM images (bank 0 low)

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cpu_addr  in  18  mapped physical address from the mapper
- cpu_ram  in  1  1 = RAM (writable), 0 = ROM (write-protected)
- cpu_mreq_n, cpu_rd_n, cpu_wr_n  in  1 each  Z80 strobes, already synchronous to clk_sys
- cpu_din  in  8  Z80 write data
- cpu_dout  out  8  read data to Z80
- cpu_wait_n  out  1  Z80 WAIT, registered
- ioctl_download  in  1  download active
- ioctl_index  in  8  0 = BASIC ROM, 1 = cartridge, others ignored
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte offset within image
- ioctl_dout  in  8  image byte
- ioctl_wait  out  1  download back-pressure
- mem_addr  out  18, mem_din  out  8, mem_we  out  1, mem_req  out  1  memory request
- mem_dout  in  8, mem_ack  in  1  one-cycle completion pulse

## Operation
- CPU access detect: cpu_mreq_n=0 and (cpu_rd_n=0 or cpu_wr_n=0) while armed. Arm is cleared on detect and set again only when cpu_mreq_n=1, so one memory transaction per Z80 cycle; refresh cycles (mreq without rd/wr) are ignored.
- FSM states: IDLE, CPU_RD, CPU_WR, DL_WR, HOLD.
- IDLE priority: a pending ioctl byte goes to DL_WR. Otherwise a detected CPU read goes to CPU_RD. A CPU write with cpu_ram=1 goes to CPU_WR. A CPU write with cpu_ram=0 is dropped: go to HOLD, no mem_req.
- CPU_RD/CPU_WR/DL_WR: drive mem_req=1 with mem_addr/mem_din/mem_we stable until mem_ack. On ack: mem_req=0. Reads latch mem_dout into cpu_dout. CPU states go to HOLD; DL_WR goes to IDLE.
- HOLD: cpu_wait_n=1; return to IDLE when cpu_mreq_n=1.
- cpu_dout holds its last value between reads.
- Download: an ioctl_wr byte is captured into a one-entry holding register. ioctl_wait=1 from the capture until that byte's mem_ack.
  - Address = base + ioctl_addr[15:0]. Base is ROM_BASE for index 0, CART_BASE for index 1.
  - Bytes with ioctl_addr[24:16]≠0 or an unknown index are discarded with no mem_req.
  - A download write ignores cpu_ram.
- CPU request detected while ioctl_download=1: held pending with cpu_wait_n=0, serviced after ioctl_download falls.
- Same-cycle ioctl_wr and CPU detect: download wins; CPU stays pending.
- Reset: state IDLE, armed=1, mem_req=0, mem_we=0, mem_addr=0, mem_din=0, cpu_dout=8'hFF, cpu_wait_n=1, ioctl_wait=0, holding register empty.
- Reset during a transaction abandons it (mem_req drops next edge). The memory must tolerate a dropped request; a late mem_ack after reset is ignored in IDLE.

## Timing
- Detect at edge N: cpu_wait_n=0 and mem_req=1 from edge N+1.
- mem_ack sampled at edge M: mem_req=0, cpu_dout valid and cpu_wait_n=1 from edge M+1.
- Minimum read latency, detect to wait release: 2 cycles when mem_ack arrives the cycle after mem_req.
- Dropped ROM write: cpu_wait_n is never asserted low.
- mem_ack outside CPU_RD/CPU_WR/DL_WR: ignored.
- ioctl bytes may arrive no faster than ioctl_wait permits. An ioctl_wr while ioctl_wait=1 is a protocol error and is dropped.

## Structure
- Package svi_mem_pkg: state enum, ROM/cartridge index constants, default base constants.
- Sub-module svi_access_detect: arm/edge logic producing one-cycle rd_req/wr_req pulses.
- FSM and datapath live in svi_mem_ctrl.

## Test plan
- Read 18'h18000, RAM, mem_ack 3 cycles after mem_req, mem_dout=8'h5A → one mem_req with we=0, cpu_dout=8'h5A, wait low for exactly 4 cycles.
- Write 8'hC3 to 18'h05000 with cpu_ram=0 → no mem_req, cpu_wait_n stays 1, cpu_dout unchanged.
- Write 8'h77 to 18'h2C000 with cpu_ram=1 → mem_addr=18'h2C000, mem_we=1, mem_din=8'h77, single transaction even though mreq is held 20 cycles.
- Download index 1, ioctl_addr=25'h0123, byte 8'hAA, while a CPU read is detected in the same cycle → download write to 18'h10123 first; CPU stays waiting until ioctl_download falls, then its read completes.
- Download index 0, ioctl_addr=25'h10000 → byte dropped, no mem_req, ioctl_wait pulses at most 1 cycle.
- reset_n low mid-CPU_RD → next edge mem_req=0, cpu_wait_n=1, cpu_dout=8'hFF; a stray mem_ack afterwards changes nothing.
